// File: rtl/syscall_unit_if.sv
// Memory bus and console byte stream shared between the syscall unit
// (master) and the memory / console sink (slave).
interface syscall_unit_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready;

  modport master (
    output mem_addr, mem_we, mem_wr_data, out_valid, out_char,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_we, mem_wr_data, out_valid, out_char,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/syscall_unit.sv
// Syscall service stage: catches the CPU's syscall request edge, decodes the
// code in sysregs and performs store / load / decimal print / char print /
// string print / halt against the shared word memory and console stream.
module syscall_unit #(
  parameter int DEBUG      = 0,
  parameter int DEC_DIGITS = 5
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          sys_signal,
  input  logic [47:0]   sysregs,
  output logic          busy,
  output logic          done,
  output logic          halted,
  output logic          load_signal,
  output logic [15:0]   load_data,
  syscall_unit_if.master bus
);
  // Trace output lives outside the synthesizable logic; DEBUG only sizes nothing.
  localparam int NCHAR = DEC_DIGITS + 0 * DEBUG;

  typedef enum logic [3:0] {
    IDLE, DISPATCH, WRITE, READ, RDWAIT, DEC_CONV, EMIT, STR_RD, STR_CHK, HALT
  } state_t;

  state_t      state_reg;
  logic        sys_q;
  logic [15:0] code_reg, arg_a_reg, arg_b_reg;
  logic [15:0] ptr_reg, rem_reg;
  logic [1:0]  dig_idx_reg;
  logic [3:0]  dig_cnt_reg;
  logic        seen_reg;
  logic [7:0]  char_reg [NCHAR];
  logic [2:0]  emit_idx_reg, emit_last_reg;
  logic        busy_reg, done_reg, halted_reg, load_signal_reg;
  logic [15:0] load_data_reg;
  logic [15:0] mem_addr_reg, mem_wr_data_reg;
  logic        mem_we_reg, out_valid_reg;
  logic [7:0]  out_char_reg;

  // Decade weights used by the subtraction-based binary-to-decimal conversion.
  function automatic logic [15:0] pow10(input logic [1:0] idx);
    case (idx)
      2'd0:    pow10 = 16'd10000;
      2'd1:    pow10 = 16'd1000;
      2'd2:    pow10 = 16'd100;
      default: pow10 = 16'd10;
    endcase
  endfunction

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign halted          = halted_reg;
  assign load_signal     = load_signal_reg;
  // The read word is forwarded during RDWAIT so the CPU sees it in the
  // same cycle as load_signal; the register holds it afterwards.
  assign load_data       = (state_reg == RDWAIT) ? bus.mem_rd_data : load_data_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_wr_data = mem_wr_data_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_char    = out_char_reg;

  // Service FSM with all outputs registered.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg       <= IDLE;
      sys_q           <= 1'b1;
      code_reg        <= '0;
      arg_a_reg       <= '0;
      arg_b_reg       <= '0;
      ptr_reg         <= '0;
      rem_reg         <= '0;
      dig_idx_reg     <= '0;
      dig_cnt_reg     <= '0;
      seen_reg        <= 1'b0;
      for (int i = 0; i < NCHAR; i++) char_reg[i] <= '0;
      emit_idx_reg    <= '0;
      emit_last_reg   <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      halted_reg      <= 1'b0;
      load_signal_reg <= 1'b0;
      load_data_reg   <= '0;
      mem_addr_reg    <= '0;
      mem_wr_data_reg <= '0;
      mem_we_reg      <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_char_reg    <= '0;
    end else begin
      sys_q      <= sys_signal;
      done_reg   <= 1'b0;
      mem_we_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sys_signal && !sys_q) begin
            code_reg  <= sysregs[15:0];
            arg_a_reg <= sysregs[31:16];
            arg_b_reg <= sysregs[47:32];
            busy_reg  <= 1'b1;
            state_reg <= DISPATCH;
            if (sysregs[15:0] != 16'd2) load_signal_reg <= 1'b0;
          end
        end
        DISPATCH: begin
          case (code_reg)
            16'd0: begin
              halted_reg <= 1'b1;
              done_reg   <= 1'b1;
              busy_reg   <= 1'b0;
              state_reg  <= HALT;
            end
            16'd1: begin
              mem_we_reg      <= 1'b1;
              mem_addr_reg    <= arg_a_reg;
              mem_wr_data_reg <= arg_b_reg;
              done_reg        <= 1'b1;
              state_reg       <= WRITE;
            end
            16'd2: begin
              mem_addr_reg <= arg_a_reg;
              state_reg    <= READ;
            end
            16'd3: begin
              rem_reg     <= arg_a_reg;
              dig_idx_reg <= 2'd0;
              dig_cnt_reg <= 4'd0;
              seen_reg    <= 1'b0;
              state_reg   <= DEC_CONV;
            end
            16'd4: begin
              char_reg[0]   <= arg_a_reg[7:0];
              out_char_reg  <= arg_a_reg[7:0];
              out_valid_reg <= 1'b1;
              emit_idx_reg  <= 3'd0;
              emit_last_reg <= 3'd0;
              state_reg     <= EMIT;
            end
            16'd5: begin
              ptr_reg      <= arg_a_reg;
              mem_addr_reg <= arg_a_reg;
              state_reg    <= STR_RD;
            end
            default: begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          endcase
        end
        WRITE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        READ: begin
          load_signal_reg <= 1'b1;
          done_reg        <= 1'b1;
          state_reg       <= RDWAIT;
        end
        RDWAIT: begin
          load_data_reg <= bus.mem_rd_data;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
        DEC_CONV: begin
          // One subtraction per cycle; a digit is committed when the
          // remainder drops below the current decade weight.
          if (rem_reg >= pow10(dig_idx_reg)) begin
            rem_reg     <= rem_reg - pow10(dig_idx_reg);
            dig_cnt_reg <= dig_cnt_reg + 4'd1;
          end else begin
            if (dig_cnt_reg != 4'd0 || seen_reg) begin
              char_reg[{1'b0, dig_idx_reg}] <= 8'h30 + {4'b0, dig_cnt_reg};
              seen_reg <= 1'b1;
            end else begin
              char_reg[{1'b0, dig_idx_reg}] <= 8'h20;
            end
            dig_cnt_reg <= 4'd0;
            if (dig_idx_reg == 2'd3) begin
              char_reg[4]   <= 8'h30 + rem_reg[7:0];
              out_char_reg  <= char_reg[0];
              out_valid_reg <= 1'b1;
              emit_idx_reg  <= 3'd0;
              emit_last_reg <= 3'(NCHAR - 1);
              state_reg     <= EMIT;
            end else begin
              dig_idx_reg <= dig_idx_reg + 2'd1;
            end
          end
        end
        EMIT: begin
          // Byte transfers on the edge where out_ready is sampled high.
          if (bus.out_ready) begin
            if (code_reg == 16'd5) begin
              out_valid_reg <= 1'b0;
              ptr_reg       <= ptr_reg + 16'd1;
              mem_addr_reg  <= ptr_reg + 16'd1;
              state_reg     <= STR_RD;
            end else if (emit_idx_reg == emit_last_reg) begin
              out_valid_reg <= 1'b0;
              done_reg      <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= IDLE;
            end else begin
              emit_idx_reg <= emit_idx_reg + 3'd1;
              out_char_reg <= char_reg[emit_idx_reg + 3'd1];
            end
          end
        end
        STR_RD: begin
          state_reg <= STR_CHK;
        end
        STR_CHK: begin
          if (bus.mem_rd_data == 16'd0) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            out_char_reg  <= bus.mem_rd_data[7:0];
            out_valid_reg <= 1'b1;
            state_reg     <= EMIT;
          end
        end
        HALT: begin
          state_reg <= HALT;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: word memory model, console sink with scoreboard of
// expected bytes, one task per scenario.
module tb_syscall_unit;
  logic        clk = 1'b0;
  logic        clear;
  logic        sys_signal;
  logic [47:0] sysregs;
  logic        busy, done, halted, load_signal;
  logic [15:0] load_data;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  logic [7:0] exp_q [$];
  logic [15:0] mem [0:65535];

  syscall_unit_if bus ();

  syscall_unit #(.DEBUG(0), .DEC_DIGITS(5)) dut (
    .clk(clk), .clear(clear), .sys_signal(sys_signal), .sysregs(sysregs),
    .busy(busy), .done(done), .halted(halted), .load_signal(load_signal),
    .load_data(load_data), .bus(bus)
  );

  always #5 clk = ~clk;

  // Word memory: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wr_data;
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  // Console sink: a transfer is seen mid-cycle and happens on the next edge.
  always @(negedge clk) begin
    if (!clear && bus.out_valid && bus.out_ready) begin
      xfers++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL console_byte unexpected got=%02h required=none", bus.out_char);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_char !== e) begin
          bad++;
          $display("FAIL console_byte got=%02h required=%02h", bus.out_char, e);
        end else begin
          $display("byte %02h", bus.out_char);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Raise the request one cycle; returns one sample after the accept edge.
  task automatic issue(input logic [15:0] code, input logic [15:0] a, input logic [15:0] b);
    $display("syscall code=%0d a=%04h b=%04h", code, a, b);
    sysregs    = {b, a, code};
    sys_signal = 1'b1;
    @(posedge clk); #1;
    sys_signal = 1'b0;
  endtask

  // Wait for done; n counts samples since accept (the first is 1).
  task automatic wait_done(input string name, input int limit, output int n);
    n = 1;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s timeout got=no_done required=done_within_%0d", name, limit);
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    clear = 1'b1; sys_signal = 1'b1; sysregs = {16'h0, 16'h0041, 16'd4};
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if ({busy, done, halted, load_signal, bus.mem_we, bus.out_valid, load_data,
         bus.mem_addr, bus.mem_wr_data, bus.out_char} !== '0) begin
      bad++; $display("FAIL reset_state got=nonzero required=0");
    end
    clear = 1'b0;
    busy_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (busy) busy_seen++; end
    total++;
    if (busy_seen != 0) begin
      bad++; $display("FAIL reset_high_level got=busy%0d required=busy0", busy_seen);
    end
    sys_signal = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int n;
    issue(16'd1, 16'h0100, 16'hBEEF);
    total++;
    if (done !== 1'b0 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL store_early got=done%b we%b required=0 0", done, bus.mem_we);
    end
    @(posedge clk); #1;
    total++;
    if ({done, bus.mem_we, bus.mem_addr, bus.mem_wr_data} !== {2'b11, 16'h0100, 16'hBEEF}) begin
      bad++; $display("FAIL store_write got=done%b we%b %04h %04h required=1 1 0100 beef",
                      done, bus.mem_we, bus.mem_addr, bus.mem_wr_data);
    end
    @(posedge clk); #1;
    total++;
    if (bus.mem_we !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL store_one_cycle got=we%b done%b required=0 0", bus.mem_we, done);
    end
    issue(16'd2, 16'h0100, 16'h0000);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL load_early got=done%b required=0", done);
    end
    @(posedge clk); #1;
    total++;
    if ({done, load_signal, load_data} !== {2'b11, 16'hBEEF}) begin
      bad++; $display("FAIL load_result got=done%b ls%b %04h required=1 1 beef",
                      done, load_signal, load_data);
    end
    @(posedge clk); #1;
    total++;
    if ({load_signal, load_data} !== {1'b1, 16'hBEEF}) begin
      bad++; $display("FAIL load_hold got=ls%b %04h required=1 beef", load_signal, load_data);
    end
    exp_q.push_back(8'h21);
    issue(16'd4, 16'h0021, 16'h0000);
    total++;
    if (load_signal !== 1'b0) begin
      bad++; $display("FAIL load_clear got=%b required=0", load_signal);
    end
    wait_done("char_after_load", 20, n);
    @(posedge clk); #1;
  endtask

  task automatic test_decimal();
    logic [15:0] vals [3];
    vals[0] = 16'd0; vals[1] = 16'd65535; vals[2] = 16'd42;
    for (int k = 0; k < 3; k++) begin
      int v, p, n, x0;
      v = int'(vals[k]);
      p = 10000;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back((v >= p) ? 8'(48 + (v / p) % 10) : 8'h20);
        p = p / 10;
      end
      exp_q.push_back(8'(48 + v % 10));
      x0 = xfers;
      issue(16'd3, vals[k], 16'h0000);
      wait_done("decimal", 60, n);
      total++;
      if (xfers - x0 != 5 || exp_q.size() != 0) begin
        bad++; $display("FAIL decimal_count val=%0d got=%0d required=5", v, xfers - x0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int n, x0, guard;
    bus.out_ready = 1'b0;
    x0 = xfers;
    issue(16'd4, 16'h0058, 16'h0000);
    guard = 0;
    while (!bus.out_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({bus.out_valid, bus.out_char} !== {1'b1, 8'h58}) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d got=v%b %02h required=1 58",
                        i, bus.out_valid, bus.out_char);
      end
      @(posedge clk); #1;
    end
    exp_q.push_back(8'h58);
    bus.out_ready = 1'b1;
    wait_done("backpressure", 20, n);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (xfers - x0 != 1) begin
      bad++; $display("FAIL backpressure_count got=%0d required=1", xfers - x0);
    end
  endtask

  task automatic test_string_wrap();
    int n, x0;
    issue(16'd1, 16'hFFFF, 16'h0048); wait_done("preload", 10, n); @(posedge clk); #1;
    issue(16'd1, 16'h0000, 16'h0069); wait_done("preload", 10, n); @(posedge clk); #1;
    issue(16'd1, 16'h0001, 16'h0000); wait_done("preload", 10, n); @(posedge clk); #1;
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    x0 = xfers;
    issue(16'd5, 16'hFFFF, 16'h0000);
    wait_done("string_wrap", 40, n);
    total++;
    if (xfers - x0 != 2 || exp_q.size() != 0) begin
      bad++; $display("FAIL string_wrap_count got=%0d required=2", xfers - x0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_edge_hold();
    int dones;
    exp_q.push_back(8'h2A);
    $display("syscall code=4 a=002a held high");
    sysregs = {16'h0, 16'h002A, 16'd4};
    sys_signal = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (i == 9) sys_signal = 1'b0;
    end
    total++;
    if (dones != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL edge_hold got=%0d required=1", dones);
    end
  endtask

  task automatic test_reset_mid_string();
    int n, guard;
    logic [7:0] s [6];
    s[0] = 8'h41; s[1] = 8'h42; s[2] = 8'h43; s[3] = 8'h44; s[4] = 8'h45; s[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      issue(16'd1, 16'h0200 + 16'(i), {8'h00, s[i]});
      wait_done("preload", 10, n);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    issue(16'd5, 16'h0200, 16'h0000);
    guard = 0;
    while (!bus.out_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    total++;
    if ({bus.out_valid, bus.out_char} !== {1'b1, 8'h41}) begin
      bad++; $display("FAIL midstring_emit got=v%b %02h required=1 41", bus.out_valid, bus.out_char);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, halted, load_signal, bus.mem_we, bus.out_valid, load_data,
         bus.mem_addr, bus.mem_wr_data, bus.out_char} !== '0) begin
      bad++; $display("FAIL midstring_reset got=busy%b v%b ld%04h addr%04h required=0",
                      busy, bus.out_valid, load_data, bus.mem_addr);
    end
    clear = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h41);
    issue(16'd4, 16'h0041, 16'h0000);
    wait_done("after_reset_char", 20, n);
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL after_reset_char got=%0d_pending required=0", exp_q.size());
    end
  endtask

  task automatic test_halt();
    int n, x0, busy_seen;
    issue(16'd0, 16'h0000, 16'h0000);
    wait_done("halt", 10, n);
    total++;
    if (halted !== 1'b1 || n != 2) begin
      bad++; $display("FAIL halt got=h%b n%0d required=1 2", halted, n);
    end
    x0 = xfers;
    busy_seen = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (2) begin @(posedge clk); #1; end
      issue(16'd4, 16'h0033, 16'h0000);
      repeat (5) begin @(posedge clk); #1; if (busy || bus.out_valid) busy_seen++; end
    end
    total++;
    if (halted !== 1'b1 || busy_seen != 0 || xfers != x0) begin
      bad++; $display("FAIL halt_ignore got=h%b act%0d x%0d required=1 0 0",
                      halted, busy_seen, xfers - x0);
    end
  endtask

  initial begin
    clear = 1'b1;
    sys_signal = 1'b0;
    sysregs = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_decimal();
    test_backpressure();
    test_string_wrap();
    test_edge_hold();
    test_reset_mid_string();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Synthesizable service stage directly downstream of the CPU's syscall outputs; replaces the behavioural syscall handling in the system top.
- Detects each syscall request, decodes the code in sysregs, and performs it against the shared 16-bit word memory.
- Results go back to the CPU on load_signal/load_data, or out as a console byte stream under a valid/ready handshake.

Parameters:
- DEBUG, 0, when nonzero, print a simulation trace line per accepted syscall; no effect on logic.
- DEC_DIGITS, 5, field width for decimal print (code 3); must be 5 for 16-bit values.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clear  in  1  asynchronous, active-high reset.
- sys_signal  in  1  CPU syscall request level; serviced on its rising edge.
- sysregs  in  48  [15:0] code, [31:16] arg A, [47:32] arg B.
- busy  out  1  high while a syscall is in service.
- done  out  1  one-cycle pulse on the completion cycle of each service.
- halted  out  1  sticky; set by code 0.
- load_signal  out  1  load result valid to the CPU.
- load_data  out  16  loaded word.
- mem_addr  out  16  memory address.
- mem_we  out  1  memory write strobe.
- mem_wr_data  out  16  memory write data.
- mem_rd_data  in  16  read data; valid exactly one cycle after mem_addr is presented.
- out_valid  out  1  console byte valid.
- out_char  out  8  console byte.
- out_ready  in  1  console sink accepts the byte when out_valid && out_ready.

Behaviour:
- Reset (clear=1, any time, including mid-service):
  - busy, done, halted, load_signal, mem_we, out_valid drop to 0 immediately.
  - load_data, mem_addr, mem_wr_data, out_char, internal registers go to 0.
  - FSM returns to IDLE; the edge detector's previous-sample register is set to 1, so a sys_signal already high at reset release is not a new request.
- Request detection:
  - Internal register sys_q samples sys_signal every cycle.
  - Accept when state==IDLE && sys_signal && !sys_q. On accept, latch code/A/B; busy=1 from the next cycle.
  - Rising edges while busy or halted are dropped, not queued.
- load_signal rule:
  - On accepting any code other than 2, load_signal clears the next cycle.
  - It holds its value through code 2 until the new data is written.
- FSM states: IDLE, DISPATCH, WRITE, READ, RDWAIT, DEC_CONV, EMIT, STR_RD, STR_CHK, HALT.
- Code 0: enter HALT; halted=1 and done pulse. The unit stays in HALT until clear.
- Code 1 (store):
  - WRITE holds mem_we=1, mem_addr=A, mem_wr_data=B for exactly one cycle.
  - done pulses that cycle; 2 cycles from accept to done.
- Code 2 (load):
  - READ drives mem_addr=A; RDWAIT captures mem_rd_data.
  - In RDWAIT, load_data<=mem_rd_data and load_signal<=1; done pulses in RDWAIT.
  - 3 cycles from accept to done.
- Code 3 (decimal):
  - Convert unsigned A to DEC_DIGITS characters, right-justified, leading zeros replaced by space (0x20). Value 0 prints "    0".
  - Conversion uses iterative subtraction of 10000/1000/100/10 and must finish in ≤50 cycles.
  - The 5 bytes are then emitted in order, most significant first.
- Code 4 (char): emit A[7:0] once.
- Code 5 (string):
  - Pointer P=A. STR_RD drives mem_addr=P; STR_CHK examines mem_rd_data.
  - A zero word ends the string: done, zero not emitted.
  - Otherwise emit mem_rd_data[7:0], then P=P+1 mod 2^16 (wraps 0xFFFF→0x0000) and repeat.
- Other codes: no-op; done pulses in DISPATCH, 2 cycles from accept.
- EMIT handshake:
  - out_valid held with out_char stable until out_ready is sampled high; the byte transfers on that edge.
  - out_valid may drop, or present the next byte, the following cycle. At most one byte transfers per cycle.
  - Back-to-back bytes with out_ready held high: one per cycle for codes 3/4.
  - Code 5 allows a gap for the memory read.
  - done pulses the cycle after the final byte transfers.
- mem_we=0 in every state except WRITE. mem_addr holds its last value when unused.

Test Plan:
- Reset mid-string: clear asserted while code 5 emits → all outputs 0 next sample; a subsequent sys_signal edge with code 4, A=0x0041 emits 0x41.
- Store/load round-trip: code 1 A=0x0100 B=0xBEEF → mem_we for one cycle, done at accept+2. Then code 2 A=0x0100 → load_data=0xBEEF, load_signal=1 at accept+3. A following code 4 clears load_signal.
- Decimal: code 3 with A=0 → "    0"; A=65535 → "65535"; A=42 → "   42". Each is exactly 5 bytes, done within 60 cycles with out_ready=1.
- Backpressure: code 4 A=0x0058 with out_ready=0 for 7 cycles → out_valid and out_char=0x58 stable; exactly one transfer when out_ready rises.
- String wrap: mem[0xFFFF]=0x48, mem[0x0000]=0x69, mem[0x0001]=0; code 5 A=0xFFFF → bytes 0x48, 0x69, then done.
- Halt and edge rules: code 0 → halted=1; later sys_signal pulses are ignored. Holding sys_signal high across 10 cycles (before halt) services once.
